// File: rtl/obi_dp_ram_port_bridge_pkg.sv
// Shared types and helpers for the OBI-to-dual-port-RAM bridge (package obi_ram_pkg).
package obi_ram_pkg;

    // One in-flight response slot.
    typedef struct packed {
        logic valid;
        logic is_write;
        logic err;
    } resp_entry_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // True when the byte address falls inside the RAM-backed window.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned ram_aw);
        return (addr >> (ram_aw + 32'd2)) == 32'd0;
    endfunction

endpackage

// File: rtl/obi_dp_ram_port_bridge_if.sv
// OBI data-side bus between the core LSU (master) and the RAM bridge (slave).
interface obi_dp_ram_port_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 22
) ();
    logic                  data_req;
    logic                  data_gnt;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic                  data_we;
    logic [3:0]            data_be;
    logic [31:0]           data_wdata;
    logic                  data_rvalid;
    logic [31:0]           data_rdata;
    logic                  data_err;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

// File: rtl/obi_dp_ram_port_bridge_resp_pipe.sv
// Fixed-depth response shift register; shifts every cycle, cleared synchronously.
module obi_resp_pipe
    import obi_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  resp_entry_t push_i,
    output resp_entry_t tail_o
);

    resp_entry_t stage_q [DEPTH];

    // Advance every stage by one slot; reset drops all in-flight entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/obi_dp_ram_port_bridge.sv
// OBI data interface to fixed-latency BRAM port B bridge.
// Optional macro OBI_RANDOM_STALL_EN: LFSR-driven grant denial (~25%).
module obi_dp_ram_port_bridge
    import obi_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 22,
    parameter int unsigned RAM_AW       = 17,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    obi_dp_ram_port_bridge_if.slave obi,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [3:0]              ram_be_o,
    output logic [31:0]             ram_wdata_o,
    input  logic [31:0]             ram_rdata_i
);

    logic                  stall;
    logic                  gnt;
    logic                  accept;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    resp_entry_t           push;
    resp_entry_t           tail;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic                  err;

`ifdef OBI_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    // Free-running Fibonacci LFSR used to deny grants pseudo-randomly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign gnt      = obi.data_req & ~rst_i & ~stall;
    assign accept   = obi.data_req & gnt;
    assign in_range = addr_in_range(32'(obi.data_addr), RAM_AW);

    assign obi.data_gnt = gnt;

    // Remember the last issued address/data so idle cycles do not toggle the RAM bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= {obi.data_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= obi.data_wdata;
        end
    end

    // Drive the RAM port in the accept cycle; out-of-range accesses stay off the RAM.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0000;
        ram_addr_o  = addr_q;
        ram_wdata_o = wdata_q;
        if (accept) begin
            ram_addr_o  = {obi.data_addr[ADDR_WIDTH-1:2], 2'b00};
            ram_wdata_o = obi.data_wdata;
            if (in_range) begin
                ram_en_o = 1'b1;
                ram_we_o = obi.data_we;
                ram_be_o = obi.data_we ? obi.data_be : 4'b0000;
            end
        end
    end

    // Tag every cycle's slot: a real transaction or an empty bubble.
    always_comb begin
        push          = '0;
        push.valid    = accept;
        push.is_write = accept & obi.data_we;
        push.err      = accept & ~in_range;
    end

    obi_resp_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .tail_o (tail)
    );

    // Response formed straight from the pipeline tail and the RAM read data.
    always_comb begin
        rvalid = 1'b0;
        rdata  = 32'h0;
        err    = 1'b0;
        if (tail.valid && !rst_i) begin
            rvalid = 1'b1;
            if (tail.err) begin
                err = 1'b1;
            end else if (!tail.is_write) begin
                rdata = ram_rdata_i;
            end
        end
    end

    assign obi.data_rvalid = rvalid;
    assign obi.data_rdata  = rdata;
    assign obi.data_err    = err;

`ifndef SYNTHESIS
    // Request payload must hold while the request waits for grant.
    property p_req_stable;
        @(posedge clk_i) disable iff (rst_i)
        (obi.data_req && !obi.data_gnt) |=>
            ($stable(obi.data_addr) && $stable(obi.data_we) &&
             $stable(obi.data_be) && $stable(obi.data_wdata));
    endproperty
    a_req_stable: assert property (p_req_stable);

    // Latency must match a supported BRAM configuration.
    a_latency_range: assert property (@(posedge clk_i)
        (READ_LATENCY >= 32'd1) && (READ_LATENCY <= 32'd4));
`endif

endmodule

// File: tb/tb_obi_dp_ram_port_bridge.sv
// Directed, table-driven bench for obi_dp_ram_port_bridge (default build, no stalls).
module tb_obi_dp_ram_port_bridge;

    localparam int unsigned AW = 22;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        ram_en;
    logic [AW-1:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] rd1;
    logic [31:0] rd2;

    int checks   = 0;
    int failures = 0;

    obi_dp_ram_port_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    obi_dp_ram_port_bridge #(
        .ADDR_WIDTH   (AW),
        .RAM_AW       (17),
        .READ_LATENCY (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .obi         (bus),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    always #5 clk = ~clk;

    // Output-registered BRAM model: two cycles from address sample to data.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            for (int i = 0; i < 8; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[10'h040] <= 32'hDEADBEEF;
            mem[10'h081] <= 32'h11223344;
            mem[10'h3FF] <= 32'hCAFEF00D;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            rd1 <= mem[ram_addr[11:2]];
        end
        rd2 <= rd1;
    end
    assign ram_rdata = rd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        bus.data_req   = req;
        bus.data_we    = we;
        bus.data_addr  = addr;
        bus.data_be    = be;
        bus.data_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
        logic          exp_en;
        logic [AW-1:0] exp_addr;
        logic [3:0]    exp_be;
        logic [31:0]   exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs [11];

    // One isolated transaction: request phase, then response exactly two cycles later.
    task automatic run_vec(input vec_t v);
        next_cycle();
        drive(1'b1, v.we, v.addr, v.be, v.wdata);
        @(negedge clk);
        check({v.name, " gnt"},    32'(bus.data_gnt), 32'd1);
        check({v.name, " en"},     32'(ram_en), 32'(v.exp_en));
        check({v.name, " we"},     32'(ram_we), 32'(v.exp_en & v.we));
        check({v.name, " be"},     32'(ram_be), 32'(v.exp_be));
        if (v.exp_en) check({v.name, " addr"}, 32'(ram_addr), 32'(v.exp_addr));
        next_cycle();
        drive(1'b0, 1'b0, v.addr, 4'b0000, 32'h0);
        @(negedge clk);
        check({v.name, " rvalid t+1"}, 32'(bus.data_rvalid), 32'd0);
        check({v.name, " en idle"},    32'(ram_en), 32'd0);
        next_cycle();
        @(negedge clk);
        check({v.name, " rvalid t+2"}, 32'(bus.data_rvalid), 32'd1);
        check({v.name, " rdata"},      bus.data_rdata, v.exp_rdata);
        check({v.name, " err"},        32'(bus.data_err), 32'(v.exp_err));
        next_cycle();
        @(negedge clk);
        check({v.name, " rvalid t+3"}, 32'(bus.data_rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{"rd 0x100",       1'b0, 22'h000100, 4'hF, 32'h0,        1'b1, 22'h000100, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{"wr 0x204 be2",   1'b1, 22'h000204, 4'h2, 32'h0000AB00, 1'b1, 22'h000204, 4'h2, 32'h0,        1'b0};
        vecs[2]  = '{"rd 0x204",       1'b0, 22'h000204, 4'hF, 32'h0,        1'b1, 22'h000204, 4'h0, 32'h1122AB44, 1'b0};
        vecs[3]  = '{"rd oor 0x80000", 1'b0, 22'h080000, 4'hF, 32'h0,        1'b0, 22'h080000, 4'h0, 32'h0,        1'b1};
        vecs[4]  = '{"wr oor 0x80100", 1'b1, 22'h080100, 4'hF, 32'h12345678, 1'b0, 22'h080100, 4'h0, 32'h0,        1'b1};
        vecs[5]  = '{"rd 0x100 again", 1'b0, 22'h000100, 4'hF, 32'h0,        1'b1, 22'h000100, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[6]  = '{"rd top 0x7fffc", 1'b0, 22'h07FFFC, 4'hF, 32'h0,        1'b1, 22'h07FFFC, 4'h0, 32'hCAFEF00D, 1'b0};
        vecs[7]  = '{"wr top 0x7fffc", 1'b1, 22'h07FFFC, 4'hF, 32'h01234567, 1'b1, 22'h07FFFC, 4'hF, 32'h0,        1'b0};
        vecs[8]  = '{"rd top new",     1'b0, 22'h07FFFC, 4'hF, 32'h0,        1'b1, 22'h07FFFC, 4'h0, 32'h01234567, 1'b0};
        vecs[9]  = '{"rd unaligned",   1'b0, 22'h000102, 4'hF, 32'h0,        1'b1, 22'h000100, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{"rd oor max",     1'b0, 22'h3FFFFC, 4'hF, 32'h0,        1'b0, 22'h3FFFFC, 4'h0, 32'h0,        1'b1};

        // Reset with a pending request: no grant, quiet response.
        rst  = 1'b1;
        load = 1'b1;
        drive(1'b1, 1'b0, 22'h000100, 4'hF, 32'h0);
        next_cycle();
        load = 1'b0;
        next_cycle();
        @(negedge clk);
        check("reset gnt",    32'(bus.data_gnt), 32'd0);
        check("reset rvalid", 32'(bus.data_rvalid), 32'd0);
        check("reset rdata",  bus.data_rdata, 32'd0);
        check("reset err",    32'(bus.data_err), 32'd0);
        check("reset ram_en", 32'(ram_en), 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
        next_cycle();

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Write immediately followed by read of the same word.
        next_cycle();
        drive(1'b1, 1'b1, 22'h000300, 4'hF, 32'h55AA55AA);
        next_cycle();
        drive(1'b1, 1'b0, 22'h000300, 4'hF, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("raw wr rvalid", 32'(bus.data_rvalid), 32'd1);
        check("raw wr rdata",  bus.data_rdata, 32'h0);
        next_cycle();
        @(negedge clk);
        check("raw rd rvalid", 32'(bus.data_rvalid), 32'd1);
        check("raw rd rdata",  bus.data_rdata, 32'h55AA55AA);
        next_cycle();
        @(negedge clk);
        check("raw idle rvalid", 32'(bus.data_rvalid), 32'd0);

        // Eight back-to-back reads: responses on consecutive cycles, in order.
        for (int c = 0; c < 11; c++) begin
            next_cycle();
            if (c < 8) drive(1'b1, 1'b0, 22'(4 * c), 4'hF, 32'h0);
            else       drive(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
            @(negedge clk);
            if (c < 8) check($sformatf("burst gnt %0d", c), 32'(bus.data_gnt), 32'd1);
            if (c >= 2 && c < 10) begin
                check($sformatf("burst rvalid %0d", c - 2), 32'(bus.data_rvalid), 32'd1);
                check($sformatf("burst rdata %0d", c - 2), bus.data_rdata, 32'hA500_0000 | 32'(c - 2));
            end else begin
                check($sformatf("burst idle rvalid c%0d", c), 32'(bus.data_rvalid), 32'd0);
            end
        end

        // Reset arriving while a read is in flight drops its response.
        next_cycle();
        drive(1'b1, 1'b0, 22'h000100, 4'hF, 32'h0);
        @(negedge clk);
        check("midrst gnt t", 32'(bus.data_gnt), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 22'h000104, 4'hF, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst gnt t+1",    32'(bus.data_gnt), 32'd0);
        check("midrst rvalid t+1", 32'(bus.data_rvalid), 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 22'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("midrst rvalid t+2", 32'(bus.data_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("midrst rvalid t+3", 32'(bus.data_rvalid), 32'd0);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
